// File: rtl/cookie_jar.sv
// cookie_jar: ROWS x COLS grid of XOR mixing cells that whitens a serial
// random-bit stream. The far-corner cell's bit is collected MSB-first into
// WIDTH-bit words and handed off over a valid/ready handshake.
//
// Ports:
//   clk         clock, single domain
//   rst         synchronous active-high reset
//   en          advance grid, collector and health counter this cycle
//   rbit        serial random input bit (feeds cell (0,0) from the left)
//   seed_load   load grid from seed_data (overrides en)
//   seed_data   grid seed, bit r*COLS+c -> cell (r,c)
//   out_valid   out_data holds a word
//   out_ready   consumer accepts the word
//   out_data    collected word, first collected bit in MSB
//   health_fail sticky repetition-test failure
//
// Build option: define COOKIE_HEALTH_EN to build the repetition health test.
// Without it health_fail is tied low and REP_LIMIT is unused.
module cookie_jar #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int WIDTH     = 8,
    parameter int REP_LIMIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 rbit,
    input  logic                 seed_load,
    input  logic [ROWS*COLS-1:0] seed_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 health_fail
);

    localparam int N  = ROWS * COLS;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    if (ROWS < 1 || COLS < 1 || WIDTH < 2 || REP_LIMIT < 2) begin : g_param_check
        $error("cookie_jar: illegal parameter combination");
    end

    // ------------------------------------------------------------------
    // Mixing grid
    // ------------------------------------------------------------------
    logic [N-1:0] grid;
    logic [N-1:0] grid_next;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic l_bit;
            logic u_bit;

            // Left neighbour; column 0 wraps to the start of the row above,
            // cell (0,0) takes the raw input bit.
            if (c > 0) begin : g_l_left
                assign l_bit = grid[r*COLS + c - 1];
            end else if (r > 0) begin : g_l_wrap
                assign l_bit = grid[(r-1)*COLS];
            end else begin : g_l_in
                assign l_bit = rbit;
            end

            // Upper neighbour only for interior cells; (0,0) gets a constant
            // 1 so it toggles when the input is quiet.
            if (r > 0 && c > 0) begin : g_u_up
                assign u_bit = grid[(r-1)*COLS + c];
            end else if (r == 0 && c == 0) begin : g_u_one
                assign u_bit = 1'b1;
            end else begin : g_u_zero
                assign u_bit = 1'b0;
            end

            assign grid_next[r*COLS + c] = grid[r*COLS + c] ^ l_bit ^ u_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grid <= '0;
        end else if (seed_load) begin
            grid <= seed_data;
        end else if (en) begin
            grid <= grid_next;
        end
    end

    // ------------------------------------------------------------------
    // Word collector and handshake
    // ------------------------------------------------------------------
    logic             b;
    logic             stalled;
    logic             collect;
    logic             word_done;
    logic [WIDTH-2:0] sh;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] word;

    assign b         = grid[N-1];
    assign stalled   = out_valid & ~out_ready;
    assign collect   = en & ~seed_load & ~stalled;
    assign word_done = collect && (cnt == CW'(WIDTH - 1));
    assign word      = {sh, b};

    always_ff @(posedge clk) begin
        if (rst) begin
            sh        <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (collect) begin
                if (word_done) begin
                    cnt <= '0;
                end else begin
                    sh  <= word[WIDTH-2:0];
                    cnt <= cnt + 1'b1;
                end
            end
            // A word completing on a transfer edge replaces the old one
            // directly, so there is no bubble under sustained ready.
            if (word_done) begin
                out_data  <= word;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Repetition health test
    // ------------------------------------------------------------------
`ifdef COOKIE_HEALTH_EN
    localparam int RW = $clog2(REP_LIMIT + 1);

    logic [RW-1:0] run;
    logic [RW-1:0] run_next;
    logic          last_bit;

    // run == 0 only right after reset, so the first collected bit starts a
    // run of 1 regardless of last_bit. The count saturates at REP_LIMIT.
    always_comb begin
        run_next = RW'(1);
        if (run != '0 && b == last_bit) begin
            run_next = (run == RW'(REP_LIMIT)) ? run : run + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run         <= '0;
            last_bit    <= 1'b0;
            health_fail <= 1'b0;
        end else if (collect) begin
            run      <= run_next;
            last_bit <= b;
            if (run_next == RW'(REP_LIMIT)) begin
                health_fail <= 1'b1;
            end
        end
    end
`else
    assign health_fail = 1'b0;
`endif

endmodule

// File: tb/tb_cookie_jar.sv
module tb_cookie_jar;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

`ifdef COOKIE_HEALTH_EN
    localparam bit HEALTH_ON = 1'b1;
`else
    localparam bit HEALTH_ON = 1'b0;
`endif

    // 1x1, WIDTH=4, REP_LIMIT=8 instance
    logic       rst1, en1, rbit1, seed_load1, out_valid1, out_ready1, health_fail1;
    logic [0:0] seed_data1;
    logic [3:0] out_data1;

    cookie_jar #(.ROWS(1), .COLS(1), .WIDTH(4), .REP_LIMIT(8)) u_small (
        .clk(clk), .rst(rst1), .en(en1), .rbit(rbit1),
        .seed_load(seed_load1), .seed_data(seed_data1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_data(out_data1), .health_fail(health_fail1)
    );

    // default 4x4, WIDTH=8 instance
    logic        rst4, en4, rbit4, seed_load4, out_valid4, out_ready4, health_fail4;
    logic [15:0] seed_data4;
    logic [7:0]  out_data4;

    cookie_jar u_big (
        .clk(clk), .rst(rst4), .en(en4), .rbit(rbit4),
        .seed_load(seed_load4), .seed_data(seed_data4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_data(out_data4), .health_fail(health_fail4)
    );

    // Reference model of the 4x4 grid and its expected word
    logic       m [4][4];
    logic [7:0] exp_word4;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = 1'b0;
        exp_word4 = 8'h00;
    endtask

    task automatic model_seed(input logic [15:0] sd);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = sd[r*4 + c];
    endtask

    task automatic model_step(input logic rb);
        logic nm [4][4];
        logic l, u;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (c > 0)      l = m[r][c-1];
                else if (r > 0) l = m[r-1][0];
                else            l = rb;
                if (r > 0 && c > 0)        u = m[r-1][c];
                else if (r == 0 && c == 0) u = 1'b1;
                else                       u = 1'b0;
                nm[r][c] = m[r][c] ^ l ^ u;
            end
        end
        m = nm;
    endtask

    // One collect cycle on the 4x4 instance, model tracked alongside
    task automatic collect4(input logic rb);
        rbit4 = rb;
        en4   = 1'b1;
        exp_word4 = {exp_word4[6:0], m[3][3]};
        model_step(rb);
        tick();
    endtask

    task automatic reset_small();
        rst1 = 1'b1; en1 = 1'b0; seed_load1 = 1'b0;
        tick();
        rst1 = 1'b0;
    endtask

    task automatic test_reset();
        rst1 = 1'b1; en1 = 1'b1; rbit1 = 1'b0; seed_load1 = 1'b0;
        seed_data1 = 1'b0; out_ready1 = 1'b1;
        rst4 = 1'b1; en4 = 1'b1; rbit4 = 1'b0; seed_load4 = 1'b0;
        seed_data4 = 16'h0000; out_ready4 = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid1 !== 1'b0 || out_data1 !== 4'h0 || health_fail1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_small: valid=%b data=%h health=%b, required 0 0 0",
                     out_valid1, out_data1, health_fail1);
        end
        checks++;
        if (out_valid4 !== 1'b0 || out_data4 !== 8'h00 || health_fail4 !== 1'b0) begin
            failures++;
            $display("FAIL reset_big: valid=%b data=%h health=%b, required 0 00 0",
                     out_valid4, out_data4, health_fail4);
        end
        rst1 = 1'b0; en1 = 1'b0;
        rst4 = 1'b0; en4 = 1'b0;
    endtask

    // Cell toggles: bits 0,1,0,1 -> 0x5, one word per 4 cycles
    task automatic test_toggle();
        reset_small();
        rbit1 = 1'b0; en1 = 1'b1; out_ready1 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (out_valid1 !== ((k % 4) == 0)) begin
                failures++;
                $display("FAIL toggle_valid k=%0d: got %b, required %b", k, out_valid1, (k % 4) == 0);
            end
            if ((k % 4) == 0) begin
                checks++;
                if (out_data1 !== 4'h5) begin
                    failures++;
                    $display("FAIL toggle_data k=%0d: got %h, required 5", k, out_data1);
                end
            end
        end
        en1 = 1'b0;
    endtask

    // Seeded cell holds 1 with rbit=1 -> 0xF; seed cycle collects nothing
    task automatic test_seed();
        reset_small();
        seed_load1 = 1'b1; seed_data1 = 1'b1; en1 = 1'b1; out_ready1 = 1'b1;
        tick();
        seed_load1 = 1'b0; rbit1 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (out_valid1 !== ((k % 4) == 0)) begin
                failures++;
                $display("FAIL seed_valid k=%0d: got %b, required %b", k, out_valid1, (k % 4) == 0);
            end
            if ((k % 4) == 0) begin
                checks++;
                if (out_data1 !== 4'hF) begin
                    failures++;
                    $display("FAIL seed_data k=%0d: got %h, required f", k, out_data1);
                end
            end
        end
        en1 = 1'b0;
    endtask

    // rbit=1 keeps the cell at 0: constant run trips at the 8th collect
    task automatic test_health();
        reset_small();
        rbit1 = 1'b1; en1 = 1'b1; out_ready1 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if (health_fail1 !== (HEALTH_ON && k >= 8)) begin
                failures++;
                $display("FAIL health k=%0d: got %b, required %b", k, health_fail1, HEALTH_ON && k >= 8);
            end
            if ((k % 4) == 0) begin
                checks++;
                if (out_valid1 !== 1'b1 || out_data1 !== 4'h0) begin
                    failures++;
                    $display("FAIL health_word k=%0d: valid=%b data=%h, required 1 0", k, out_valid1, out_data1);
                end
            end
        end
        en1 = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (health_fail1 !== HEALTH_ON) begin
            failures++;
            $display("FAIL health_sticky: got %b, required %b", health_fail1, HEALTH_ON);
        end
        reset_small();
        checks++;
        if (health_fail1 !== 1'b0) begin
            failures++;
            $display("FAIL health_clear: got %b, required 0", health_fail1);
        end
    endtask

    // Backpressure: word held through 21 stalled edges while the grid keeps
    // toggling, so the next word starts on the other phase (0xA).
    task automatic test_backpressure();
        reset_small();
        rbit1 = 1'b0; en1 = 1'b1; out_ready1 = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        checks++;
        if (out_valid1 !== 1'b1 || out_data1 !== 4'h5) begin
            failures++;
            $display("FAIL stall_first: valid=%b data=%h, required 1 5", out_valid1, out_data1);
        end
        for (int k = 5; k <= 25; k++) begin
            tick();
            checks++;
            if (out_valid1 !== 1'b1 || out_data1 !== 4'h5) begin
                failures++;
                $display("FAIL stall_hold k=%0d: valid=%b data=%h, required 1 5", k, out_valid1, out_data1);
            end
        end
        out_ready1 = 1'b1;
        for (int k = 26; k <= 29; k++) begin
            tick();
            checks++;
            if (out_valid1 !== (k == 29)) begin
                failures++;
                $display("FAIL stall_release_valid k=%0d: got %b, required %b", k, out_valid1, k == 29);
            end
        end
        checks++;
        if (out_data1 !== 4'hA) begin
            failures++;
            $display("FAIL stall_next_word: got %h, required a", out_data1);
        end
        // handshake completes even with en low
        en1 = 1'b0;
        tick();
        checks++;
        if (out_valid1 !== 1'b0) begin
            failures++;
            $display("FAIL handshake_en_low: valid=%b, required 0", out_valid1);
        end
    endtask

    // 4x4: reset mid-word and during a held word; collector restarts cleanly
    task automatic test_rst_midword();
        logic [7:0] en_pat;
        logic [7:0] rb_pat;
        en_pat = 8'b1011_0110;
        rb_pat = 8'b1100_1010;
        rst4 = 1'b1; tick(); rst4 = 1'b0;
        out_ready4 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            en4 = en_pat[k]; rbit4 = rb_pat[k];
            tick();
        end
        rst4 = 1'b1; en4 = 1'b1;
        tick();
        rst4 = 1'b0;
        model_reset();
        checks++;
        if (out_valid4 !== 1'b0 || out_data4 !== 8'h00 || health_fail4 !== 1'b0) begin
            failures++;
            $display("FAIL rst_midword: valid=%b data=%h health=%b, required 0 00 0",
                     out_valid4, out_data4, health_fail4);
        end
        out_ready4 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            collect4(rb_pat[k]);
            checks++;
            if (out_valid4 !== (k == 7)) begin
                failures++;
                $display("FAIL restart_valid k=%0d: got %b, required %b", k, out_valid4, k == 7);
            end
        end
        checks++;
        if (out_data4 !== exp_word4) begin
            failures++;
            $display("FAIL restart_word: got %h, required %h", out_data4, exp_word4);
        end
        for (int k = 0; k < 3; k++) begin
            rbit4 = k[0];
            tick();
        end
        checks++;
        if (out_valid4 !== 1'b1 || out_data4 !== exp_word4) begin
            failures++;
            $display("FAIL big_hold: valid=%b data=%h, required 1 %h", out_valid4, out_data4, exp_word4);
        end
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        model_reset();
        checks++;
        if (out_valid4 !== 1'b0 || out_data4 !== 8'h00) begin
            failures++;
            $display("FAIL rst_during_valid: valid=%b data=%h, required 0 00", out_valid4, out_data4);
        end
        out_ready4 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            collect4(en_pat[k]);
            checks++;
            if (out_valid4 !== (k == 7)) begin
                failures++;
                $display("FAIL post_rst_valid k=%0d: got %b, required %b", k, out_valid4, k == 7);
            end
        end
        checks++;
        if (out_data4 !== exp_word4) begin
            failures++;
            $display("FAIL post_rst_word: got %h, required %h", out_data4, exp_word4);
        end
        en4 = 1'b0;
    endtask

    // 4x4: seed_load with en high loads the grid and collects no bit
    task automatic test_seed_en();
        rst4 = 1'b1; tick(); rst4 = 1'b0;
        model_reset();
        out_ready4 = 1'b1;
        for (int k = 0; k < 3; k++) collect4(1'b0);
        seed_load4 = 1'b1; seed_data4 = 16'hA5C3; en4 = 1'b1; rbit4 = 1'b1;
        tick();
        model_seed(16'hA5C3);
        seed_load4 = 1'b0;
        checks++;
        if (out_valid4 !== 1'b0) begin
            failures++;
            $display("FAIL seed_en_valid: got %b, required 0", out_valid4);
        end
        for (int k = 0; k < 5; k++) begin
            collect4(k[0]);
            checks++;
            if (out_valid4 !== (k == 4)) begin
                failures++;
                $display("FAIL seed_en_count k=%0d: got %b, required %b", k, out_valid4, k == 4);
            end
        end
        checks++;
        if (out_data4 !== exp_word4 || exp_word4[4] !== 1'b1) begin
            failures++;
            $display("FAIL seed_en_word: got %h, required %h", out_data4, exp_word4);
        end
        en4 = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_toggle();
        test_seed();
        test_health();
        test_backpressure();
        test_rst_midword();
        test_seed_en();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cookie_jar.md
# cookie_jar

Parametrised ROWS x COLS grid of XOR mixing cells that turns a serial random-bit input into WIDTH-bit words. Each cell mixes its own state with its left and upper neighbours every enabled cycle. The bit from the far corner cell is collected into words and handed off with a valid/ready handshake. It sits between the raw entropy source and downstream word consumers, and adds seed loading, word packing, backpressure and an optional repetition health test.

## Interface
- ROWS, 4, grid rows (>=1)
- COLS, 4, grid columns (>=1)
- WIDTH, 8, output word width (>=2)
- REP_LIMIT, 16, run length of identical collected bits that trips the health test (>=2)
- clk  in  1  clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- en  in  1  advance grid and collector this cycle
- rbit  in  1  serial random input bit
- seed_load  in  1  load grid state from seed_data
- seed_data  in  ROWS*COLS  seed; bit r*COLS+c goes to cell (r,c)
- out_valid  out  1  out_data holds a word
- out_ready  in  1  consumer accepts word
- out_data  out  WIDTH  collected word, first collected bit in MSB
- health_fail  out  1  sticky repetition-test failure

## Operation
- Cell state s[r][c], 1 bit each. Next state = s ^ L ^ U.
  - L: s[r][c-1] if c>0; else s[r-1][0] if r>0; else rbit.
  - U: s[r-1][c] if r>0 and c>0; 1 for cell (0,0); 0 otherwise.
- Grid update priority: rst > seed_load > en. With seed_load, all cells load seed_data regardless of en. With none of these, the grid holds.
- Output bit b = s[ROWS-1][COLS-1], taken before the update in the same cycle.
- Collector has a WIDTH-1 bit shift register sh and a bit count cnt (0..WIDTH-1).
  - A collect cycle is one with en=1, seed_load=0, and not stalled.
  - On a collect cycle with cnt<WIDTH-1: sh <= {sh, b}, cnt++.
  - On a collect cycle with cnt==WIDTH-1: out_data <= {sh, b}, out_valid <= 1, cnt <= 0.
- Stall: the collector is stalled while out_valid=1 and out_ready=0. The grid keeps updating during a stall; the bits produced are discarded.
- Transfer occurs when out_valid and out_ready are both high at a clock edge. out_valid clears unless a new word completes on the same edge, in which case the new word loads with no bubble.
- out_data is stable while out_valid=1 and out_ready=0.
- seed_load does not clear sh or cnt.
- Health test: run counter of identical consecutive collected bits, counting only collect cycles. When the run reaches REP_LIMIT, health_fail is set and stays set until rst. Data flow is unaffected.

## Timing
- Reset values: all s=0, sh=0, cnt=0, out_valid=0, out_data=0, health_fail=0.
- rst mid-word or mid-handshake drops the pending word; out_valid=0 in the next cycle.
- Seed-to-grid latency: 1 cycle.
- First word: out_valid rises after the WIDTH-th collect edge following reset.
- Sustained throughput with out_ready=1: one word per WIDTH en cycles.
- All outputs are registered; there is no combinational path from any input to any output.
- en=0 freezes grid, collector and health counter; the handshake still completes.

## Configuration
- COOKIE_HEALTH_EN defined: the repetition counter and REP_LIMIT compare are built, and health_fail behaves as above.
- COOKIE_HEALTH_EN undefined: no health logic is built, health_fail is tied to 0, and REP_LIMIT is ignored.

## Test plan
- ROWS=COLS=1, WIDTH=4; reset, then rbit=0, en=1, out_ready=1 → cell toggles, collected bits 0,1,0,1; out_valid rises after 4th edge with out_data=0x5; same word repeats every 4 cycles.
- ROWS=COLS=1, WIDTH=4; seed_load with seed_data=1, then rbit=1, en=1 → cell holds 1; out_data=0xF every 4 cycles.
- ROWS=COLS=1, WIDTH=4, REP_LIMIT=8, COOKIE_HEALTH_EN defined; rbit=1, en=1 from reset → words 0x0; health_fail=1 after 8th collect edge, held until rst. Without the macro: health_fail stays 0.
- ROWS=COLS=1, WIDTH=4, rbit=0, out_ready=0 → first word 0x5 held with out_valid=1 and out_data stable for 20 cycles; raise out_ready → transfer; next word appears 4 collect edges later.
- Default 4x4, random rbit/en; assert rst mid-word and during out_valid → next cycle all outputs are at reset values and cnt restarts; no stale word delivered.
- Default 4x4; seed_load and en high together → grid equals seed_data next cycle; collector advanced for 0 bits that cycle.
